char_ram_writer: RTL and testbench

- Write-side counterpart of the character ROM read path.
- Accepts 7-bit ASCII codes over a valid/ready handshake and writes them into the dual-port text RAM at a managed cursor position.
- The display path reads that RAM to choose which glyph to fetch.
- Interprets a small set of control codes (CR, LF, BS, FF) and clears the screen on reset.

---
 rtl/char_ram_writer_pkg.sv | 31 +++
 rtl/char_ram_writer_if.sv | 17 +
 rtl/char_ram_writer_cursor_ctrl.sv | 70 +++++++
 rtl/char_ram_writer.sv | 141 ++++++++++++++
 tb/tb_char_ram_writer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/char_ram_writer_pkg.sv
// Shared constants, state/command enums and the row*COLS+col address helper
// for the text-RAM writer.
package char_pkg;

  localparam logic [6:0] ASC_CR    = 7'h0D;
  localparam logic [6:0] ASC_LF    = 7'h0A;
  localparam logic [6:0] ASC_BS    = 7'h08;
  localparam logic [6:0] ASC_FF    = 7'h0C;
  localparam logic [6:0] ASC_SP    = 7'h20;
  localparam logic [6:0] ASC_PR_LO = 7'h20;
  localparam logic [6:0] ASC_PR_HI = 7'h7E;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 60;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} wr_state_e;

  typedef enum logic [2:0] {CUR_NONE, CUR_INC, CUR_DEC, CUR_CR, CUR_LF, CUR_HOME} cur_cmd_e;

  // Constant multiply by cols unrolled into shifted adds of row (80 -> <<6 + <<4).
  function automatic logic [15:0] lin_addr(input logic [5:0] row, input logic [6:0] col,
                                           input int unsigned cols);
    logic [15:0] acc;
    acc = {9'd0, col};
    for (int unsigned i = 0; i < 8; i++) begin
      if (cols[i]) acc = acc + ({10'd0, row} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/char_ram_writer_if.sv
// Character source / text-RAM write bundle for char_ram_writer.
interface char_ram_writer_if #(parameter int unsigned ADDR_W = 13);
  logic [6:0]        Char_in;
  logic              Valid;
  logic              Ready;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [6:0]        WrData;
  logic [5:0]        Cursor_Fila;
  logic [6:0]        Cursor_Col;
  logic              Busy;

  modport master (output Char_in, Valid,
                  input  Ready, WrEn, WrAddr, WrData, Cursor_Fila, Cursor_Col, Busy);
  modport slave  (input  Char_in, Valid,
                  output Ready, WrEn, WrAddr, WrData, Cursor_Fila, Cursor_Col, Busy);
endinterface

// File: rtl/char_ram_writer_cursor_ctrl.sv
// Cursor row/column registers with advance, back-step, CR, LF and home commands;
// rows wrap to 0 past the last row (no scrolling).
module cursor_ctrl
  import char_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  cur_cmd_e          cmd_i,
  output logic [5:0]        row_o,
  output logic [6:0]        col_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);

  logic [5:0] row_q, row_d, row_inc;
  logic [6:0] col_q, col_d;

  assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + 6'd1;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (cmd_i)
      CUR_INC: begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CUR_DEC: begin
        if (col_q != '0) begin
          col_d = col_q - 7'd1;
        end else if (row_q != '0) begin
          row_d = row_q - 6'd1;
          col_d = COL_MAX;
        end
      end
      CUR_CR:   col_d = '0;
      CUR_LF:   row_d = row_inc;
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = ADDR_W'(lin_addr(row_q, col_q, COLS));

endmodule

// File: rtl/char_ram_writer.sv
// Accepts ASCII codes over valid/ready and writes them into the text RAM at the
// cursor, handling CR/LF/BS/FF and a full-screen clear after reset.
module char_ram_writer
  import char_pkg::*;
#(
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic             NCLK,
  input  logic             NRST,
  char_ram_writer_if.slave bus
);

  localparam int unsigned CELLS = COLS * ROWS;

  wr_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [6:0]        wdata_q, wdata_d;
  cur_cmd_e          cur_cmd;
  logic [ADDR_W-1:0] cur_addr;
  logic [5:0]        cur_row;
  logic [6:0]        cur_col;
  logic              printable;

  cursor_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk_i  (NCLK),
    .rst_ni (NRST),
    .cmd_i  (cur_cmd),
    .row_o  (cur_row),
    .col_o  (cur_col),
    .addr_o (cur_addr)
  );

  assign printable = (bus.Char_in >= ASC_PR_LO) && (bus.Char_in <= ASC_PR_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cur_cmd = CUR_NONE;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.Valid && ready_q) begin
          ready_d = 1'b0;
          state_d = WRITE;
          if (printable) begin
            wren_d  = 1'b1;
            waddr_d = cur_addr;
            wdata_d = bus.Char_in;
            cur_cmd = CUR_INC;
          end else begin
            case (bus.Char_in)
              ASC_CR: cur_cmd = CUR_CR;
              ASC_LF: cur_cmd = CUR_LF;
              ASC_BS: begin
                // Back-stepped cell is always addr-1, including the row wrap; (0,0) stays.
                wren_d  = 1'b1;
                waddr_d = (cur_addr == '0) ? '0 : cur_addr - ADDR_W'(1);
                wdata_d = ASC_SP;
                cur_cmd = CUR_DEC;
              end
              ASC_FF: begin
                // Cell 0 is written on the accept edge so the clear spans exactly CELLS cycles.
                state_d = CLEAR;
                busy_d  = 1'b1;
                wren_d  = 1'b1;
                waddr_d = '0;
                wdata_d = ASC_SP;
                cnt_d   = (ADDR_W+1)'(1);
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      CLEAR: begin
        busy_d = 1'b1;
        if (cnt_q == (ADDR_W+1)'(CELLS)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          cur_cmd = CUR_HOME;
        end else begin
          wren_d  = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = ASC_SP;
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge NCLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RESET != 0);
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.Ready       = ready_q;
  assign bus.Busy        = busy_q;
  assign bus.WrEn        = wren_q;
  assign bus.WrAddr      = waddr_q;
  assign bus.WrData      = wdata_q;
  assign bus.Cursor_Fila = cur_row;
  assign bus.Cursor_Col  = cur_col;

endmodule

// File: tb/tb_char_ram_writer.sv
// Randomized self-checking bench for char_ram_writer against a cursor/screen
// model expressed with plain row/column arithmetic.
module tb_char_ram_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic NCLK;
  logic NRST;

  char_ram_writer_if #(.ADDR_W(13)) bus();

  char_ram_writer #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .ADDR_W         (13),
    .CLEAR_ON_RESET (1)
  ) dut (
    .NCLK (NCLK),
    .NRST (NRST),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_row = 0;
  int m_col = 0;

  initial begin
    NCLK = 1'b0;
    forever #5 NCLK = ~NCLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Checks CELLS consecutive clear writes; started=1 means the current negedge is the first.
  task automatic check_clear(input bit started);
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (!(started && i == 0)) @(negedge NCLK);
      if (bus.WrEn !== 1'b1 || bus.WrAddr !== 13'(i) || bus.WrData !== 7'h20 ||
          bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk("clear_bad_cycles", bad, 0);
    chk("clear_first_bad", first_bad, -1);
    @(negedge NCLK);
    chk("clear_done_ready", bus.Ready, 1);
    chk("clear_done_busy", bus.Busy, 0);
    chk("clear_done_wren", bus.WrEn, 0);
    chk("clear_done_row", bus.Cursor_Fila, 0);
    chk("clear_done_col", bus.Cursor_Col, 0);
    m_row = 0;
    m_col = 0;
  endtask

  // Called and returns at a negedge.
  task automatic send_code(input logic [6:0] c, input bit hold = 1'b0);
    int waited = 0;
    int r = m_row;
    int cl = m_col;
    bit exp_we = 1'b0;
    int exp_addr = 0;
    int exp_data = 0;
    bit is_ff = 1'b0;
    bus.Char_in = c;
    bus.Valid = 1'b1;
    while (bus.Ready !== 1'b1 && waited < 10000) begin
      @(negedge NCLK);
      waited++;
    end
    if (waited >= 10000) begin
      chk("accept_timeout", 0, 1);
      bus.Valid = 1'b0;
      return;
    end
    if (c >= 7'h20 && c <= 7'h7E) begin
      exp_we = 1'b1;
      exp_addr = r * COLS + cl;
      exp_data = int'(c);
      cl++;
      if (cl == COLS) begin
        cl = 0;
        r = (r + 1) % ROWS;
      end
    end else if (c == 7'h0D) begin
      cl = 0;
    end else if (c == 7'h0A) begin
      r = (r + 1) % ROWS;
    end else if (c == 7'h08) begin
      if (cl > 0) cl--;
      else if (r > 0) begin
        r--;
        cl = COLS - 1;
      end
      exp_we = 1'b1;
      exp_addr = r * COLS + cl;
      exp_data = 32;
    end else if (c == 7'h0C) begin
      is_ff = 1'b1;
    end
    @(posedge NCLK);
    @(negedge NCLK);
    bus.Valid = 1'b0;
    if (is_ff) begin
      if (hold) begin
        bus.Valid = 1'b1;
        bus.Char_in = 7'h41;
      end
      check_clear(1'b1);
      return;
    end
    chk("write_en", bus.WrEn, exp_we);
    if (exp_we) begin
      chk("write_addr", bus.WrAddr, exp_addr);
      chk("write_data", bus.WrData, exp_data);
    end
    chk("cursor_row", bus.Cursor_Fila, r);
    chk("cursor_col", bus.Cursor_Col, cl);
    chk("ready_low", bus.Ready, 0);
    chk("busy_low", bus.Busy, 0);
    m_row = r;
    m_col = cl;
    @(negedge NCLK);
    chk("ready_back", bus.Ready, 1);
    chk("wren_idle", bus.WrEn, 0);
  endtask

  function automatic logic [6:0] rand_print();
    return 7'($urandom_range(32, 126));
  endfunction

  initial begin
    logic [6:0] c;
    NRST = 1'b1;
    bus.Valid = 1'b0;
    bus.Char_in = 7'h00;
    #2 NRST = 1'b0;
    #1;
    chk("rst_wren", bus.WrEn, 0);
    chk("rst_addr", bus.WrAddr, 0);
    chk("rst_data", bus.WrData, 0);
    chk("rst_ready", bus.Ready, 0);
    chk("rst_busy", bus.Busy, 1);
    chk("rst_row", bus.Cursor_Fila, 0);
    chk("rst_col", bus.Cursor_Col, 0);
    repeat (2) @(negedge NCLK);
    NRST = 1'b1;
    check_clear(1'b0);

    send_code(7'h41);
    send_code(7'h42);
    chk("ab_row", bus.Cursor_Fila, 0);
    chk("ab_col", bus.Cursor_Col, 2);

    repeat (77) send_code(rand_print());
    send_code(7'h41);
    chk("wrap_col_row", bus.Cursor_Fila, 1);

    send_code(7'h0D);
    repeat (58) send_code(7'h0A);
    repeat (79) send_code(rand_print());
    chk("corner_col", bus.Cursor_Col, 79);
    send_code(7'h41);
    chk("corner_wrap_row", bus.Cursor_Fila, 0);
    chk("corner_wrap_col", bus.Cursor_Col, 0);

    repeat (3) send_code(7'h0A);
    repeat (10) send_code(rand_print());
    send_code(7'h0D);
    send_code(7'h0A);
    send_code(7'h08);
    chk("bs_row", bus.Cursor_Fila, 3);
    chk("bs_col", bus.Cursor_Col, 79);
    send_code(7'h0D);
    repeat (57) send_code(7'h0A);
    send_code(7'h08);
    chk("bs_home_row", bus.Cursor_Fila, 0);
    chk("bs_home_col", bus.Cursor_Col, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        6: c = 7'h0D;
        7: c = 7'h0A;
        8: c = 7'h08;
        9: begin
          c = 7'($urandom_range(0, 31));
          if (c == 7'h08 || c == 7'h0A || c == 7'h0C || c == 7'h0D) c = 7'h7F;
        end
        default: c = rand_print();
      endcase
      send_code(c);
    end

    send_code(7'h0D);
    while (m_row != 10) send_code(7'h0A);
    repeat (5) send_code(rand_print());
    send_code(7'h0C, 1'b1);
    send_code(7'h41);

    @(negedge NCLK);
    NRST = 1'b0;
    @(negedge NCLK);
    NRST = 1'b1;
    for (int i = 0; i < 2000 && !(bus.WrEn === 1'b1 && bus.WrAddr === 13'd1000); i++)
      @(negedge NCLK);
    chk("reach_addr_1000", bus.WrAddr, 1000);
    NRST = 1'b0;
    #1;
    chk("abort_wren", bus.WrEn, 0);
    chk("abort_addr", bus.WrAddr, 0);
    chk("abort_busy", bus.Busy, 1);
    chk("abort_ready", bus.Ready, 0);
    @(negedge NCLK);
    NRST = 1'b1;
    check_clear(1'b0);

    repeat (7) send_code(rand_print());
    send_code(7'h7F);
    send_code(7'h01);
    chk("ignore_col", bus.Cursor_Col, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
